// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate test sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_SCAN   = 2'b10
  } state_t;

  localparam int unsigned NUM_FN  = 9;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned SW_W    = 18;
  localparam int unsigned GREEN_W = 9;
  localparam int unsigned PASS_W  = 8;

  localparam logic [SEL_W-1:0] FN_NOT     = 4'd0;
  localparam logic [SEL_W-1:0] FN_AND2    = 4'd1;
  localparam logic [SEL_W-1:0] FN_OR2     = 4'd2;
  localparam logic [SEL_W-1:0] FN_AND3    = 4'd3;
  localparam logic [SEL_W-1:0] FN_OR3     = 4'd4;
  localparam logic [SEL_W-1:0] FN_NAND4   = 4'd5;
  localparam logic [SEL_W-1:0] FN_NOR4    = 4'd6;
  localparam logic [SEL_W-1:0] FN_AND_OR  = 4'd7;
  localparam logic [SEL_W-1:0] FN_AND_XOR = 4'd8;

  localparam logic [SW_W-1:0] MASK_NOT  = 18'h20000;
  localparam logic [SW_W-1:0] MASK_2IN  = 18'h18000;
  localparam logic [SW_W-1:0] MASK_3IN  = 18'h07000;
  localparam logic [SW_W-1:0] MASK_4IN  = 18'h00F00;
  localparam logic [SW_W-1:0] MASK_AO   = 18'h000F0;
  localparam logic [SW_W-1:0] MASK_AX   = 18'h0000F;

  // Switches feeding the function at a given index; zero for invalid indices.
  function automatic logic [SW_W-1:0] red_mask(input logic [SEL_W-1:0] idx);
    logic [SW_W-1:0] m;
    m = '0;
    case (idx)
      FN_NOT:             m = MASK_NOT;
      FN_AND2, FN_OR2:    m = MASK_2IN;
      FN_AND3, FN_OR3:    m = MASK_3IN;
      FN_NAND4, FN_NOR4:  m = MASK_4IN;
      FN_AND_OR:          m = MASK_AO;
      FN_AND_XOR:         m = MASK_AX;
      default:            m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_button_debouncer.sv
// Active-low button synchronizer and debouncer producing a one-cycle press pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Sync the button, count stable-low cycles, pulse once on reaching the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      meta  <= button_n;
      sync  <= meta;
      press <= 1'b0;
      if (sync) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
        cnt   <= cnt + CNT_W'(1);
        press <= (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
      end
    end
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Steps through the lab's nine boolean functions and drives the matching LEDs.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        CLOCK_50_I,
  input  logic        RESET_I,
  input  logic [17:0] SWITCH_I,
  input  logic [3:0]  PUSH_BUTTON_I,
  output logic [8:0]  LED_GREEN_O,
  output logic [17:0] LED_RED_O,
  output logic [3:0]  SEL_O,
  output logic [1:0]  MODE_O,
  output logic [7:0]  PASS_COUNT_O
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  logic [3:0]         press;
  logic [SW_W-1:0]    sw_meta;
  logic [SW_W-1:0]    sw_sync;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [PASS_W-1:0]  pass_q, pass_d;

  logic [GREEN_W-1:0] green_c;
  logic [SW_W-1:0]    red_c;

  logic press_mode, press_next, press_prev, press_stop;

  // One debouncer per push button: [0] mode, [1] next, [2] previous, [3] stop.
  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk      (CLOCK_50_I),
      .reset    (RESET_I),
      .button_n (PUSH_BUTTON_I[i]),
      .press    (press[i])
    );
  end

  assign press_mode = press[0];
  assign press_next = press[1];
  assign press_prev = press[2];
  assign press_stop = press[3];

  // Two-flop synchronizer for the toggle switches.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SWITCH_I;
      sw_sync <= sw_meta;
    end
  end

  // FSM state, index, scan tick and pass counter registers.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      tick_q  <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: stop beats mode beats next/previous.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tick_d  = tick_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (press_mode) state_d = ST_MANUAL;
      end
      ST_MANUAL: begin
        if (press_stop) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (press_mode) begin
          state_d = ST_SCAN;
          tick_d  = '0;
        end else if (press_next && !press_prev) begin
          sel_d = (sel_q == SEL_W'(NUM_FN - 1)) ? '0 : sel_q + SEL_W'(1);
        end else if (press_prev && !press_next) begin
          sel_d = (sel_q == '0) ? SEL_W'(NUM_FN - 1) : sel_q - SEL_W'(1);
        end
      end
      ST_SCAN: begin
        if (press_stop) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (press_mode) begin
          state_d = ST_MANUAL;
        end else if (tick_q == TICK_W'(TICK_DIV - 1)) begin
          tick_d = '0;
          if (sel_q == SEL_W'(NUM_FN - 1)) begin
            sel_d = '0;
            if (pass_q != '1) pass_d = pass_q + PASS_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
    // Recover from an out-of-range index regardless of state.
    if (sel_q >= SEL_W'(NUM_FN)) sel_d = '0;
  end

  // Evaluate the selected function and its input mask; dark in IDLE.
  always_comb begin
    green_c = '0;
    red_c   = sw_sync & red_mask(sel_q);
    case (sel_q)
      FN_NOT:     green_c[8] = ~sw_sync[17];
      FN_AND2:    green_c[7] = &sw_sync[16:15];
      FN_OR2:     green_c[6] = |sw_sync[16:15];
      FN_AND3:    green_c[5] = &sw_sync[14:12];
      FN_OR3:     green_c[4] = |sw_sync[14:12];
      FN_NAND4:   green_c[3] = ~&sw_sync[11:8];
      FN_NOR4:    green_c[2] = ~|sw_sync[11:8];
      FN_AND_OR:  green_c[1] = (sw_sync[7] & sw_sync[6]) | (sw_sync[5] & sw_sync[4]);
      FN_AND_XOR: green_c[0] = (sw_sync[3] & sw_sync[2]) ^ (sw_sync[1] & sw_sync[0]);
      default:    green_c    = '0;
    endcase
    if (state_q == ST_IDLE) begin
      green_c = '0;
      red_c   = '0;
    end
  end

  // Registered LED outputs.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      LED_GREEN_O <= '0;
      LED_RED_O   <= '0;
    end else begin
      LED_GREEN_O <= green_c;
      LED_RED_O   <= red_c;
    end
  end

  assign SEL_O        = sel_q;
  assign MODE_O       = state_q;
  assign PASS_COUNT_O = pass_q;

endmodule
